// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: captures decoded operands/control, detects load-use
// hazards, inserts bubbles, and forwards MEM/WB results into the EX operands.
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [XLEN-1:0]   id_pc_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic [XLEN-1:0]   id_rD1_i,
  input  logic [XLEN-1:0]   id_rD2_i,
  input  logic [XLEN-1:0]   id_ext_i,
  input  logic [4:0]        id_wR_i,
  input  logic              id_rf_we_i,
  input  logic              id_is_load_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              flush_i,
  input  logic              ex_hold_i,
  input  logic              mem_rf_we_i,
  input  logic [4:0]        mem_wR_i,
  input  logic [XLEN-1:0]   mem_wD_i,
  input  logic              wb_rf_we_i,
  input  logic [4:0]        wb_wR_i,
  input  logic [XLEN-1:0]   wb_wD_i,
  output logic              lu_stall_o,
  output logic              ex_valid_o,
  output logic [XLEN-1:0]   ex_pc_o,
  output logic [XLEN-1:0]   ex_ext_o,
  output logic [4:0]        ex_wR_o,
  output logic              ex_rf_we_o,
  output logic              ex_is_load_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [XLEN-1:0]   ex_op1_o,
  output logic [XLEN-1:0]   ex_op2_o
);

  logic              valid_q, valid_d;
  logic [XLEN-1:0]   pc_q, pc_d, ext_q, ext_d, rD1_q, rD1_d, rD2_q, rD2_d;
  logic [4:0]        wR_q, wR_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic              rf_we_q, rf_we_d, is_load_q, is_load_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  logic lu_stall;
  logic wb_hit1, wb_hit2;
  logic mem_fw1, mem_fw2, wb_fw1, wb_fw2;

  // A frozen pipe cannot advance, so a hazard is irrelevant while held.
  assign lu_stall = id_valid_i & valid_q & is_load_q & rf_we_q & (wR_q != 5'd0) &
                    ((wR_q == id_rs1_i) | (wR_q == id_rs2_i)) & ~ex_hold_i;
  assign lu_stall_o = lu_stall;

  // Regfile is read-before-write: catch the value WB writes this same edge.
  assign wb_hit1 = wb_rf_we_i & (wb_wR_i != 5'd0) & (wb_wR_i == id_rs1_i);
  assign wb_hit2 = wb_rf_we_i & (wb_wR_i != 5'd0) & (wb_wR_i == id_rs2_i);

  always_comb begin
    valid_d   = valid_q;
    pc_d      = pc_q;
    ext_d     = ext_q;
    rD1_d     = rD1_q;
    rD2_d     = rD2_q;
    wR_d      = wR_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rf_we_d   = rf_we_q;
    is_load_d = is_load_q;
    ctrl_d    = ctrl_q;
    if (ex_hold_i) begin
      // keep everything
    end else if (flush_i | lu_stall) begin
      valid_d   = 1'b0;
      pc_d      = '0;
      ext_d     = '0;
      rD1_d     = '0;
      rD2_d     = '0;
      wR_d      = '0;
      rs1_d     = '0;
      rs2_d     = '0;
      rf_we_d   = 1'b0;
      is_load_d = 1'b0;
      ctrl_d    = '0;
    end else begin
      valid_d   = id_valid_i;
      pc_d      = id_pc_i;
      ext_d     = id_ext_i;
      rD1_d     = wb_hit1 ? wb_wD_i : id_rD1_i;
      rD2_d     = wb_hit2 ? wb_wD_i : id_rD2_i;
      wR_d      = id_wR_i;
      rs1_d     = id_rs1_i;
      rs2_d     = id_rs2_i;
      rf_we_d   = id_rf_we_i & id_valid_i;
      is_load_d = id_is_load_i & id_valid_i;
      ctrl_d    = id_valid_i ? id_ctrl_i : '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      pc_q      <= '0;
      ext_q     <= '0;
      rD1_q     <= '0;
      rD2_q     <= '0;
      wR_q      <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rf_we_q   <= 1'b0;
      is_load_q <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      ext_q     <= ext_d;
      rD1_q     <= rD1_d;
      rD2_q     <= rD2_d;
      wR_q      <= wR_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rf_we_q   <= rf_we_d;
      is_load_q <= is_load_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // MEM is younger than WB, so it wins when both target the same register.
  assign mem_fw1 = mem_rf_we_i & (mem_wR_i != 5'd0) & (mem_wR_i == rs1_q);
  assign mem_fw2 = mem_rf_we_i & (mem_wR_i != 5'd0) & (mem_wR_i == rs2_q);
  assign wb_fw1  = wb_rf_we_i  & (wb_wR_i  != 5'd0) & (wb_wR_i  == rs1_q);
  assign wb_fw2  = wb_rf_we_i  & (wb_wR_i  != 5'd0) & (wb_wR_i  == rs2_q);

  assign ex_op1_o = mem_fw1 ? mem_wD_i : (wb_fw1 ? wb_wD_i : rD1_q);
  assign ex_op2_o = mem_fw2 ? mem_wD_i : (wb_fw2 ? wb_wD_i : rD2_q);

  assign ex_valid_o   = valid_q;
  assign ex_pc_o      = pc_q;
  assign ex_ext_o     = ext_q;
  assign ex_wR_o      = wR_q;
  assign ex_rf_we_o   = rf_we_q & valid_q;
  assign ex_is_load_o = is_load_q & valid_q;
  assign ex_ctrl_o    = valid_q ? ctrl_q : '0;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push expectations, a
// negedge monitor pops and compares against the DUT.
module tb_id_ex_stage;
  localparam int XLEN = 32, CTRL_W = 16;

  logic clk = 1'b0, rst;
  logic id_valid, id_rf_we, id_is_load, flush, ex_hold, mem_rf_we, wb_rf_we;
  logic [XLEN-1:0] id_pc, id_rD1, id_rD2, id_ext, mem_wD, wb_wD;
  logic [4:0] id_rs1, id_rs2, id_wR, mem_wR, wb_wR;
  logic [CTRL_W-1:0] id_ctrl;
  logic lu_stall, ex_valid, ex_rf_we, ex_is_load;
  logic [XLEN-1:0] ex_pc, ex_ext, ex_op1, ex_op2;
  logic [4:0] ex_wR;
  logic [CTRL_W-1:0] ex_ctrl;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_pc_i(id_pc),
    .id_rs1_i(id_rs1), .id_rs2_i(id_rs2), .id_rD1_i(id_rD1), .id_rD2_i(id_rD2),
    .id_ext_i(id_ext), .id_wR_i(id_wR), .id_rf_we_i(id_rf_we), .id_is_load_i(id_is_load),
    .id_ctrl_i(id_ctrl), .flush_i(flush), .ex_hold_i(ex_hold),
    .mem_rf_we_i(mem_rf_we), .mem_wR_i(mem_wR), .mem_wD_i(mem_wD),
    .wb_rf_we_i(wb_rf_we), .wb_wR_i(wb_wR), .wb_wD_i(wb_wD),
    .lu_stall_o(lu_stall), .ex_valid_o(ex_valid), .ex_pc_o(ex_pc), .ex_ext_o(ex_ext),
    .ex_wR_o(ex_wR), .ex_rf_we_o(ex_rf_we), .ex_is_load_o(ex_is_load),
    .ex_ctrl_o(ex_ctrl), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2));

  typedef struct {
    string       name;
    logic        v, st, we;
    logic [4:0]  m;    // {we, ctrl, wR, op2, op1} check enables
    logic [31:0] op1, op2;
    logic [4:0]  wr;
    logic [15:0] ctrl;
  } exp_t;

  exp_t q[$];
  int n_vec = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Monitor: compares whatever expectation is pending at each negedge.
  initial forever begin
    @(negedge clk);
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      chk({e.name, ".valid"}, {31'd0, ex_valid}, {31'd0, e.v});
      chk({e.name, ".lu_stall"}, {31'd0, lu_stall}, {31'd0, e.st});
      if (e.m[0]) chk({e.name, ".op1"}, ex_op1, e.op1);
      if (e.m[1]) chk({e.name, ".op2"}, ex_op2, e.op2);
      if (e.m[2]) chk({e.name, ".wR"}, {27'd0, ex_wR}, {27'd0, e.wr});
      if (e.m[3]) chk({e.name, ".ctrl"}, {16'd0, ex_ctrl}, {16'd0, e.ctrl});
      if (e.m[4]) chk({e.name, ".rf_we"}, {31'd0, ex_rf_we}, {31'd0, e.we});
    end
  end

  task automatic ex(input string n, input logic v, input logic st, input logic [4:0] m,
                    input logic [31:0] o1, input logic [31:0] o2, input logic [4:0] wr,
                    input logic [15:0] c, input logic we);
    exp_t e;
    e.name = n; e.v = v; e.st = st; e.m = m; e.op1 = o1; e.op2 = o2;
    e.wr = wr; e.ctrl = c; e.we = we;
    q.push_back(e);
  endtask

  task automatic idin(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                      input logic [31:0] d1, input logic [31:0] d2, input logic [4:0] wr,
                      input logic we, input logic ld, input logic [15:0] c);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_rD1 = d1; id_rD2 = d2; id_wR = wr;
    id_rf_we = we; id_is_load = ld; id_ctrl = c; id_pc = d1 + 32'h100; id_ext = d2 + 1;
  endtask

  task automatic fw(input logic mw, input logic [4:0] mr, input logic [31:0] md,
                    input logic ww, input logic [4:0] wr, input logic [31:0] wd);
    mem_rf_we = mw; mem_wR = mr; mem_wD = md; wb_rf_we = ww; wb_wR = wr; wb_wD = wd;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; ex_hold = 1'b0;
    fw(0, 0, 0, 0, 0, 0);
    idin(1, 1, 2, 32'h9, 32'h8, 5'd4, 1, 0, 16'hFFFF);
    cyc(); cyc();
    ex("reset", 0, 0, 5'b01001, 32'h0, 0, 0, 16'h0, 0);
    cyc();
    // add x3, x1, x2
    rst = 1'b0;
    idin(1, 1, 2, 32'd5, 32'd7, 5'd3, 1, 0, 16'h0123);
    ex("post_reset", 0, 0, 5'b01000, 0, 0, 0, 16'h0, 0);
    cyc();
    idin(1, 2, 0, 32'd100, 32'd0, 5'd5, 1, 1, 16'h0456);      // lw x5
    ex("add_load", 1, 0, 5'b11111, 32'd5, 32'd7, 5'd3, 16'h0123, 1);
    cyc();
    idin(1, 5, 1, 32'd11, 32'd22, 5'd6, 1, 0, 16'h0789);      // add x6,x5,x1
    ex("lu_hazard", 1, 1, 5'b11100, 0, 0, 5'd5, 16'h0456, 1);
    cyc();
    ex("lu_bubble", 0, 0, 5'b11100, 0, 0, 5'd0, 16'h0, 0);
    cyc();
    // MEM and WB both hit ex_rs1 -> MEM wins; hold keeps EX stable
    fw(1, 5, 32'hAA, 1, 5, 32'hBB);
    ex_hold = 1'b1;
    ex("fwd_mem", 1, 0, 5'b11111, 32'hAA, 32'd22, 5'd6, 16'h0789, 1);
    cyc();
    mem_rf_we = 1'b0;
    ex("fwd_wb", 1, 0, 5'b01111, 32'hBB, 32'd22, 5'd6, 16'h0789, 0);
    cyc();
    // x0 is never forwarded or bypassed
    ex_hold = 1'b0;
    fw(1, 0, 32'hFF, 1, 0, 32'hFF);
    idin(1, 0, 7, 32'd0, 32'h33, 5'd8, 1, 0, 16'h0AAA);
    ex("x0_pre", 1, 0, 5'b00011, 32'd11, 32'd22, 0, 0, 0);
    cyc();
    ex_hold = 1'b1;
    ex("x0_fwd", 1, 0, 5'b01111, 32'd0, 32'h33, 5'd8, 16'h0AAA, 0);
    cyc();
    // WB capture bypass on rs1
    ex_hold = 1'b0;
    fw(0, 0, 0, 1, 9, 32'h99);
    idin(1, 9, 0, 32'h1, 32'h2, 5'd10, 1, 0, 16'h0BBB);
    ex("x0_held", 1, 0, 5'b00011, 32'd0, 32'h33, 0, 0, 0);
    cyc();
    // flush together with hold: nothing changes
    fw(0, 0, 0, 0, 0, 0);
    flush = 1'b1; ex_hold = 1'b1;
    idin(1, 3, 4, 32'h5A, 32'h5B, 5'd12, 1, 0, 16'h0CCC);
    ex("wb_bypass", 1, 0, 5'b01111, 32'h99, 32'h2, 5'd10, 16'h0BBB, 0);
    cyc();
    flush = 1'b0; ex_hold = 1'b0;
    idin(1, 0, 0, 32'h40, 32'h0, 5'd13, 1, 1, 16'h0DDD);      // lw x13
    ex("flush_hold", 1, 0, 5'b01101, 32'h99, 0, 5'd10, 16'h0BBB, 0);
    cyc();
    // flush with a load-use hazard present: one bubble, stall still raised
    flush = 1'b1;
    idin(1, 13, 0, 32'h1, 32'h2, 5'd14, 1, 0, 16'h0EEE);
    ex("flush_lu", 1, 1, 5'b11100, 0, 0, 5'd13, 16'h0DDD, 1);
    cyc();
    flush = 1'b0;
    idin(0, 0, 0, 32'h7, 32'h7, 5'd15, 1, 1, 16'h0F0F);
    ex("flush_bubble", 0, 0, 5'b11000, 0, 0, 0, 16'h0, 0);
    cyc();
    idin(0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
    ex("invalid_load", 0, 0, 5'b11100, 0, 0, 5'd15, 16'h0, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) begin
      n_vec++; n_bad++;
      $display("FAIL drain: %0d expectations pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
